// File: rtl/int_controller.sv
// int_controller: latches edge-detect interrupt pulses as pending, masks them,
// picks the lowest eligible index and hands it to the CPU via IRQ/ACK, then
// holds it in service until EOI. No nesting.
module int_controller #(
  parameter int N_SRC = 16,
  parameter int VEC_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_int_req,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_data,
  input  logic             i_gie,
  output logic             o_irq,
  output logic [VEC_W-1:0] o_irq_vec,
  input  logic             i_irq_ack,
  input  logic             i_eoi,
  output logic             o_in_service,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_mask
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic             r_irq;
  logic [VEC_W-1:0] r_vec;
  logic             r_inService;

  logic [N_SRC-1:0] w_elig;
  logic             w_anyElig;
  logic [VEC_W-1:0] w_selIdx;
  logic [N_SRC-1:0] w_vecOneHot;
  logic             w_vecElig;
  logic             w_ackAccept;
  logic [N_SRC-1:0] w_clrMask;

  // Sources that may interrupt right now: pending, unmasked, globally enabled.
  always_comb begin
    w_elig    = i_gie ? (r_pending & r_mask) : '0;
    w_anyElig = |w_elig;
  end

  // Fixed-priority pick: scanning downward leaves the lowest set index.
  always_comb begin
    w_selIdx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_selIdx = VEC_W'(i);
      end
    end
  end

  // One-hot of the latched vector, used both to clear pending and to test
  // whether the outstanding request is still eligible.
  always_comb begin
    w_vecOneHot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_vecOneHot[i] = (r_vec == VEC_W'(i));
    end
  end

  // ACK only counts while a request is actually outstanding.
  always_comb begin
    w_ackAccept = (r_state == ST_REQ) && i_irq_ack;
    w_vecElig   = |(w_elig & w_vecOneHot);
    w_clrMask   = w_ackAccept ? w_vecOneHot : '0;
  end

  // Pending bits: a new pulse always sets, accepted ACK clears; set beats clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clrMask) | i_int_req;
    end
  end

  // Mask register, software loaded; arbitration sees it from the next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '0;
    end else if (i_mask_we) begin
      r_mask <= i_mask_data;
    end
  end

  // Handshake FSM with registered IRQ, vector and in-service outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_irq       <= 1'b0;
      r_vec       <= '0;
      r_inService <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyElig) begin
            r_vec   <= w_selIdx;
            r_irq   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_irq_ack) begin
            r_irq       <= 1'b0;
            r_inService <= 1'b1;
            r_state     <= ST_SERVICE;
          end else if (!w_vecElig) begin
            r_irq   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (i_eoi) begin
            r_inService <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_irq       <= 1'b0;
          r_inService <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_irq        = r_irq;
  assign o_irq_vec    = r_vec;
  assign o_in_service = r_inService;
  assign o_pending    = r_pending;
  assign o_mask       = r_mask;

endmodule

// File: tb/tb_int_controller.sv
// Directed testbench for int_controller with hand-computed expectations.
module tb_int_controller;

  logic        clk;
  logic        rstN;
  logic [15:0] intReq;
  logic        maskWe;
  logic [15:0] maskData;
  logic        gie;
  logic        irq;
  logic [3:0]  irqVec;
  logic        irqAck;
  logic        eoi;
  logic        inService;
  logic [15:0] pending;
  logic [15:0] mask;

  int totalChecks = 0;
  int failChecks  = 0;

  int_controller #(.N_SRC(16), .VEC_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_int_req    (intReq),
    .i_mask_we    (maskWe),
    .i_mask_data  (maskData),
    .i_gie        (gie),
    .o_irq        (irq),
    .o_irq_vec    (irqVec),
    .i_irq_ack    (irqAck),
    .i_eoi        (eoi),
    .o_in_service (inService),
    .o_pending    (pending),
    .o_mask       (mask)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      failChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstN = 1'b0; intReq = '0; maskWe = 1'b0; maskData = '0;
    gie = 1'b0; irqAck = 1'b0; eoi = 1'b0;
    #3;
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_mask", 32'(mask), 32'h0);
    checkOutput("rst_vec", 32'(irqVec), 32'h0);
    checkOutput("rst_insvc", 32'(inService), 32'h0);
    applyStimulus();
    applyStimulus();
    rstN = 1'b1;
    applyStimulus();

    // Basic path
    maskWe = 1'b1; maskData = 16'hFFFF; gie = 1'b1;
    applyStimulus();
    maskWe = 1'b0;
    checkOutput("mask_load", 32'(mask), 32'hFFFF);
    intReq = 16'h0020;
    applyStimulus();
    intReq = '0;
    checkOutput("basic_pending", 32'(pending), 32'h0020);
    checkOutput("basic_irq_early", 32'(irq), 32'h0);
    applyStimulus();
    checkOutput("basic_irq", 32'(irq), 32'h1);
    checkOutput("basic_vec", 32'(irqVec), 32'h5);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    checkOutput("basic_ack_pending", 32'(pending), 32'h0);
    checkOutput("basic_ack_irq", 32'(irq), 32'h0);
    checkOutput("basic_insvc", 32'(inService), 32'h1);
    checkOutput("basic_svc_vec", 32'(irqVec), 32'h5);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("basic_eoi_insvc", 32'(inService), 32'h0);
    applyStimulus();
    checkOutput("basic_idle_irq", 32'(irq), 32'h0);

    // Priority
    intReq = 16'h0208;
    applyStimulus();
    intReq = '0;
    checkOutput("prio_pending", 32'(pending), 32'h0208);
    applyStimulus();
    checkOutput("prio_irq1", 32'(irq), 32'h1);
    checkOutput("prio_vec1", 32'(irqVec), 32'h3);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    checkOutput("prio_pending_after", 32'(pending), 32'h0200);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("prio_eoi_irq", 32'(irq), 32'h0);
    applyStimulus();
    checkOutput("prio_irq2", 32'(irq), 32'h1);
    checkOutput("prio_vec2", 32'(irqVec), 32'h9);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;

    // Masked pending, then unmask
    maskWe = 1'b1; maskData = 16'h0000;
    applyStimulus();
    maskWe = 1'b0;
    intReq = 16'h0004;
    applyStimulus();
    intReq = '0;
    checkOutput("masked_pending", 32'(pending), 32'h0004);
    applyStimulus();
    applyStimulus();
    checkOutput("masked_irq", 32'(irq), 32'h0);
    maskWe = 1'b1; maskData = 16'h0004;
    applyStimulus();
    maskWe = 1'b0;
    checkOutput("unmask_irq_early", 32'(irq), 32'h0);
    applyStimulus();
    checkOutput("unmask_irq", 32'(irq), 32'h1);
    checkOutput("unmask_vec", 32'(irqVec), 32'h2);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    eoi = 1'b1;
    maskWe = 1'b1; maskData = 16'hFFFF;
    applyStimulus();
    eoi = 1'b0; maskWe = 1'b0;

    // Higher priority during REQ does not replace; GIE drop withdraws
    intReq = 16'h0010;
    applyStimulus();
    intReq = '0;
    applyStimulus();
    checkOutput("wd_vec4", 32'(irqVec), 32'h4);
    intReq = 16'h0002;
    applyStimulus();
    intReq = '0;
    checkOutput("wd_hold_irq", 32'(irq), 32'h1);
    checkOutput("wd_hold_vec", 32'(irqVec), 32'h4);
    gie = 1'b0;
    applyStimulus();
    checkOutput("wd_irq_drop", 32'(irq), 32'h0);
    checkOutput("wd_pending", 32'(pending), 32'h0012);
    applyStimulus();
    checkOutput("wd_stay_idle", 32'(irq), 32'h0);
    gie = 1'b1;
    applyStimulus();
    checkOutput("wd_rereq_vec", 32'(irqVec), 32'h1);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    checkOutput("wd_ack_pending", 32'(pending), 32'h0010);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    applyStimulus();
    checkOutput("wd_vec4_again", 32'(irqVec), 32'h4);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;

    // No nesting during SERVICE; stray ACK ignored
    intReq = 16'h0080;
    applyStimulus();
    intReq = '0;
    applyStimulus();
    checkOutput("nest_vec7", 32'(irqVec), 32'h7);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    intReq = 16'h0001;
    applyStimulus();
    intReq = '0;
    checkOutput("nest_pending", 32'(pending), 32'h0001);
    checkOutput("nest_irq", 32'(irq), 32'h0);
    checkOutput("nest_vec_hold", 32'(irqVec), 32'h7);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    checkOutput("nest_stray_ack_pending", 32'(pending), 32'h0001);
    checkOutput("nest_stray_ack_insvc", 32'(inService), 32'h1);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    checkOutput("nest_eoi_irq", 32'(irq), 32'h0);
    checkOutput("nest_eoi_insvc", 32'(inService), 32'h0);
    applyStimulus();
    checkOutput("nest_next_irq", 32'(irq), 32'h1);
    checkOutput("nest_next_vec", 32'(irqVec), 32'h0);
    irqAck = 1'b1;
    applyStimulus();
    irqAck = 1'b0;
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;

    // Set/clear collision on the same bit
    intReq = 16'h0040;
    applyStimulus();
    intReq = '0;
    applyStimulus();
    checkOutput("coll_vec6", 32'(irqVec), 32'h6);
    intReq = 16'h0040; irqAck = 1'b1;
    applyStimulus();
    intReq = '0; irqAck = 1'b0;
    checkOutput("coll_pending", 32'(pending), 32'h0040);
    checkOutput("coll_insvc", 32'(inService), 32'h1);
    eoi = 1'b1;
    applyStimulus();
    eoi = 1'b0;
    applyStimulus();
    checkOutput("coll_rereq_irq", 32'(irq), 32'h1);
    checkOutput("coll_rereq_vec", 32'(irqVec), 32'h6);

    // Asynchronous reset in the middle of REQ, between edges
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_irq", 32'(irq), 32'h0);
    checkOutput("arst_pending", 32'(pending), 32'h0);
    checkOutput("arst_mask", 32'(mask), 32'h0);
    checkOutput("arst_insvc", 32'(inService), 32'h0);
    checkOutput("arst_vec", 32'(irqVec), 32'h0);

    $display("%0d/%0d checks passed", totalChecks - failChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Sits directly downstream of the per-port edge-detect interrupt generators.
- Each generator's INT_FLAG pulse drives one bit of INT_REQ; the bit index is that generator's INT_NO.
- The block latches requests as pending, applies a mask and a global enable, and selects one source by fixed priority.
- It presents the selected vector to the CPU through an IRQ/ACK handshake and holds it in service until EOI.

Parameters:
- N_SRC, 16, number of interrupt sources (1..16). Must satisfy 2^VEC_W >= N_SRC.
- VEC_W, 4, width of the vector number; matches the width of INT_NO.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- INT_REQ  in  N_SRC  request pulses; bit i comes from the generator with INT_NO = i.
- MASK_WE  in  1  mask write strobe.
- MASK_DATA  in  N_SRC  mask value; 1 = source enabled.
- GIE  in  1  global interrupt enable.
- IRQ  out  1  interrupt request to the CPU.
- IRQ_VEC  out  VEC_W  vector number of the source being requested or serviced.
- IRQ_ACK  in  1  CPU accepts the current request.
- EOI  in  1  CPU signals end of interrupt service.
- IN_SERVICE  out  1  an interrupt is currently being serviced.
- PENDING  out  N_SRC  pending register, readable by software.
- MASK  out  N_SRC  mask register readback.

Behaviour:
- Reset (RST_N = 0, asynchronous, takes effect immediately, including mid-handshake):
  - State goes to IDLE.
  - PENDING, MASK, IRQ, IRQ_VEC and IN_SERVICE all go to 0.
- Pending register:
  - On each edge, PENDING[i] is set when INT_REQ[i] = 1, regardless of MASK and GIE.
  - PENDING[i] is cleared only by an accepted ACK for vector i.
  - If a set and a clear for the same bit occur in the same cycle, the set wins and the bit stays 1.
  - A request that arrives while its bit is already pending merges into that bit; nothing is counted.
- Mask register:
  - With MASK_WE = 1, MASK is loaded from MASK_DATA at the edge.
  - The new mask takes effect for arbitration from the next cycle.
- Eligibility:
  - ELIG = PENDING & MASK, gated by GIE.
  - The selected source is the lowest set index of ELIG; index 0 has the highest priority.
- State machine, three states:
  - IDLE: IRQ = 0 and IN_SERVICE = 0. If ELIG is nonzero, at the next edge IRQ_VEC is loaded with the selected index, IRQ is set to 1 and the state goes to REQ.
  - REQ: IRQ = 1 and IRQ_VEC is held stable. A higher-priority request arriving in this state does not replace the vector.
    - If IRQ_ACK = 1: at the edge, clear PENDING[IRQ_VEC], set IRQ to 0, set IN_SERVICE to 1, go to SERVICE.
    - Otherwise, if the latched vector is no longer eligible (its mask bit is cleared or GIE = 0): withdraw, setting IRQ to 0 and going to IDLE. PENDING is kept.
    - If both conditions hold in the same cycle, ACK takes priority.
  - SERVICE: IRQ = 0, IN_SERVICE = 1, IRQ_VEC holds the serviced source. There is no nesting; new requests only accumulate in PENDING.
    - EOI = 1: at the edge, IN_SERVICE goes to 0 and the state goes to IDLE.
- Ignored inputs: IRQ_ACK outside REQ and EOI outside SERVICE have no effect.
- Latency:
  - INT_REQ sampled at edge k → PENDING visible after edge k → IRQ = 1 after edge k+1.
  - EOI sampled at edge m → state IDLE after edge m → earliest next IRQ after edge m+1.
- Index bounds: INT_REQ bits at index N_SRC and above do not exist; IRQ_VEC never exceeds N_SRC-1.

Test Plan:
- Basic path: reset, MASK = 0xFFFF, GIE = 1, pulse INT_REQ[5] for one cycle.
  - IRQ = 1 two edges later with IRQ_VEC = 5.
  - ACK → PENDING[5] = 0, IN_SERVICE = 1.
  - EOI → IDLE, IRQ stays 0.
- Priority: pulse INT_REQ[3] and INT_REQ[9] in the same cycle.
  - IRQ_VEC = 3 first; after ACK and EOI, IRQ_VEC = 9.
  - PENDING reads 0x0208 before the first ACK.
- Masked pending: MASK = 0x0000, pulse INT_REQ[2].
  - PENDING = 0x0004, IRQ stays 0.
  - Write MASK = 0x0004 → IRQ = 1 with IRQ_VEC = 2 two cycles after the write strobe.
- Withdraw and no nesting:
  - In REQ for vector 4, clear GIE → IRQ drops next edge, state IDLE, PENDING[4] still 1.
  - Separately, a pulse on INT_REQ[0] during SERVICE of vector 7 → no IRQ until EOI, then IRQ_VEC = 0.
- Set/clear collision: INT_REQ[6] pulses in the same cycle that ACK accepts vector 6 → PENDING[6] = 1 afterward.
- Asynchronous reset: assert RST_N = 0 mid-REQ between clock edges → IRQ, PENDING and MASK read 0 immediately, without waiting for an edge.
